// File: rtl/dog_diff_pipe_pkg.sv
// sift_pkg: shared defaults, width helper and the position-tag type used by
// the DoG stage of the SIFT pipeline.
//   PIX_W_DEF / COLS_DEF / ROWS_DEF : default pixel width and frame geometry
//   dog_w(pix_w)                    : width of one signed DoG difference
//   pos_tag_t                       : {sof, eol, eof} raster position flags
package sift_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int COLS_DEF  = 640;
  localparam int ROWS_DEF  = 480;

  // Difference of two unsigned PIX_W values needs one extra sign bit.
  function automatic int dog_w(input int pix_w);
    return pix_w + 1;
  endfunction

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pos_tag_t;
endpackage

// File: rtl/dog_diff_pipe_if.sv
// dog_diff_pipe_if: valid/ready stream bundle for the DoG stage.
//   in_valid/in_ready/in_pix       : SCALES blurred pixels per beat
//   out_valid/out_ready/out_dog    : SCALES-1 signed differences per beat
//   out_mask                       : per-layer candidate flags
//   out_sof/out_eol/out_eof        : raster position tags
// Modports: master = upstream/downstream environment, slave = the DoG block.
interface dog_diff_pipe_if
  import sift_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int SCALES = 4
) ();
  localparam int DW = dog_w(PIX_W);

  logic                        in_valid;
  logic                        in_ready;
  logic [SCALES*PIX_W-1:0]     in_pix;
  logic                        out_valid;
  logic                        out_ready;
  logic [(SCALES-1)*DW-1:0]    out_dog;
  logic [SCALES-2:0]           out_mask;
  logic                        out_sof;
  logic                        out_eol;
  logic                        out_eof;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_dog, out_mask, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_dog, out_mask, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/dog_diff_pipe_pos_cnt.sv
// dog_pos_cnt: col/row raster counter for accepted beats.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance one pixel (accepted beat)
//   tag        : {sof, eol, eof} for the current (pre-increment) position
module dog_pos_cnt
  import sift_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output pos_tag_t tag
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col, last_row;

  assign last_col = (col == CW'(COLS-1));
  assign last_row = (row == RW'(ROWS-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign tag.sof = (col == '0) && (row == '0);
  assign tag.eol = last_col;
  assign tag.eof = last_col && last_row;
endmodule

// File: rtl/dog_diff_pipe.sv
// dog_diff_pipe: two-stage Difference-of-Gaussian stage.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dog_diff_pipe_if.slave (input pixels, output DoG + tags)
// Stage 1 registers pix[k+1]-pix[k] per layer and the raster tag; stage 2
// drives the outputs. Whole pipe advances together when the output slot is
// empty or being taken, so in_ready never depends on in_valid.
// Optional build macro DOG_THRESH_EN: out_mask[k] = |dog[k]| >= THRESH;
// without it out_mask is constant zero.
module dog_diff_pipe
  import sift_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int SCALES = 4,
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int THRESH = 3
) (
  input logic            clk,
  input logic            rst_n,
  dog_diff_pipe_if.slave bus
);
  localparam int DW     = dog_w(PIX_W);
  localparam int L      = SCALES - 1;
  localparam int STAGES = 2;

  logic                  adv, acc;
  logic [STAGES:1]       vld_pipe;
  logic [L-1:0][DW-1:0]  d_c, s1_d, out_d;
  pos_tag_t              tag_c, s1_tag, out_tag;

  assign adv          = !vld_pipe[STAGES] || bus.out_ready;
  assign acc          = bus.in_valid && adv;
  assign bus.in_ready = adv;

  dog_pos_cnt #(.COLS(COLS), .ROWS(ROWS)) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .tag   (tag_c)
  );

  // Zero-extend both operands so the subtraction is exact in DW bits.
  for (genvar k = 0; k < L; k++) begin : g_diff
    assign d_c[k] = {1'b0, bus.in_pix[(k+1)*PIX_W +: PIX_W]}
                  - {1'b0, bus.in_pix[k*PIX_W +: PIX_W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_d     <= '0;
      s1_tag   <= '0;
      out_d    <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      s1_d     <= d_c;
      s1_tag   <= acc ? tag_c : '0;
      out_d    <= s1_d;
      out_tag  <= s1_tag;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_dog   = out_d;
  assign bus.out_sof   = out_tag.sof;
  assign bus.out_eol   = out_tag.eol;
  assign bus.out_eof   = out_tag.eof;

`ifdef DOG_THRESH_EN
  logic [L-1:0] mask_c, mask_q;

  // Magnitude of -(2^PIX_W-1) still fits in PIX_W unsigned bits.
  for (genvar k = 0; k < L; k++) begin : g_mask
    logic [PIX_W-1:0] mag;
    assign mag       = s1_d[k][DW-1] ? PIX_W'(-s1_d[k]) : s1_d[k][PIX_W-1:0];
    assign mask_c[k] = {1'b0, mag} >= DW'(THRESH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   mask_q <= '0;
    else if (adv) mask_q <= mask_c;
  end

  assign bus.out_mask = mask_q;
`else
  assign bus.out_mask = '0;
`endif
endmodule

// File: tb/tb_dog_diff_pipe.sv
// tb_dog_diff_pipe: scoreboard bench for dog_diff_pipe (PIX_W=8, SCALES=4,
// COLS=4, ROWS=2, THRESH=3). Expected beats are queued at acceptance and
// compared when the DUT presents them.
module tb_dog_diff_pipe;
  localparam int PIX_W = 8, SCALES = 4, COLS = 4, ROWS = 2, THRESH = 3;

  typedef struct {
    logic [26:0] dog;
    logic [2:0]  mask;
    logic [2:0]  tags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   col = 0, row = 0;
  exp_t q[$];
  logic ir;

  dog_diff_pipe_if #(.PIX_W(PIX_W), .SCALES(SCALES)) bus ();

  dog_diff_pipe #(
    .PIX_W(PIX_W), .SCALES(SCALES), .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] p);
    exp_t e;
    logic [8:0] d;
    e.dog  = '0;
    e.mask = '0;
    for (int k = 0; k < 3; k++) begin
      d = {1'b0, p[(k+1)*8 +: 8]} - {1'b0, p[k*8 +: 8]};
      e.dog[k*9 +: 9] = d;
`ifdef DOG_THRESH_EN
      e.mask[k] = ($signed(d) >= THRESH) || ($signed(d) <= -THRESH);
`endif
    end
    e.tags = {(col == 0 && row == 0), (col == COLS-1), (col == COLS-1 && row == ROWS-1)};
    return e;
  endfunction

  task automatic advance_pos();
    if (col == COLS-1) begin
      col = 0;
      row = (row == ROWS-1) ? 0 : row + 1;
    end else begin
      col++;
    end
  endtask

  // One clock: drive, sample in_ready mid-cycle, queue accepted beat.
  task automatic cyc(input logic v, input logic [31:0] pix, input logic rdy,
                     output logic ready_seen);
    bus.in_valid  = v;
    bus.in_pix    = pix;
    bus.out_ready = rdy;
    @(negedge clk);
    ready_seen = bus.in_ready;
    if (v && bus.in_ready) begin
      q.push_back(model(pix));
      advance_pos();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    col = 0;
    row = 0;
  endtask

  // Scoreboard: compare whatever the DUT presents; pop only when delivered.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1'b1, 1'b0);
      end else begin
        chk("sb_dog", bus.out_dog, q[0].dog);
        chk("sb_mask", bus.out_mask, q[0].mask);
        chk("sb_tags", {bus.out_sof, bus.out_eol, bus.out_eof}, q[0].tags);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0] m1, m2;
`ifdef DOG_THRESH_EN
    m1 = 3'b011;
    m2 = 3'b111;
`else
    m1 = 3'b000;
    m2 = 3'b000;
`endif
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_dog", bus.out_dog, 27'd0);
    chk("rst_mask", bus.out_mask, 3'd0);
    chk("rst_tags", {bus.out_sof, bus.out_eol, bus.out_eof}, 3'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Basic diff, with explicit 2-cycle latency.
    cyc(1'b1, {8'd15, 8'd15, 8'd20, 8'd10}, 1'b1, ir);
    chk("lat_s1", bus.out_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, ir);
    chk("lat_out", bus.out_valid, 1'b1);
    chk("basic_dog", bus.out_dog, {9'h000, 9'h1FB, 9'h00A});
    chk("basic_mask", bus.out_mask, m1);
    chk("basic_sof", bus.out_sof, 1'b1);

    // Extremes.
    cyc(1'b1, {8'd0, 8'd255, 8'd0, 8'd255}, 1'b1, ir);
    cyc(1'b0, '0, 1'b1, ir);
    chk("ext_dog", bus.out_dog, {9'h101, 9'h0FF, 9'h101});
    chk("ext_mask", bus.out_mask, m2);

    // Raster tags across a frame wrap (scoreboard checks tags).
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b1, ir);
    repeat (3) cyc(1'b0, '0, 1'b1, ir);

    // Backpressure: three stalled cycles after first output.
    cyc(1'b1, $urandom, 1'b1, ir);
    cyc(1'b1, $urandom, 1'b1, ir);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, $urandom, 1'b0, ir);
      chk("stall_in_ready", ir, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1, ir);
    repeat (3) cyc(1'b0, '0, 1'b1, ir);

    // Bubbles: valid 1,0,1 -> out_valid 1,0,1 two cycles later.
    cyc(1'b1, $urandom, 1'b1, ir);
    cyc(1'b0, '0, 1'b1, ir);
    chk("bub_v0", bus.out_valid, 1'b1);
    cyc(1'b1, $urandom, 1'b1, ir);
    chk("bub_v1", bus.out_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, ir);
    chk("bub_v2", bus.out_valid, 1'b1);
    cyc(1'b0, '0, 1'b1, ir);
    chk("bub_v3", bus.out_valid, 1'b0);

    // Reset mid-frame after 5 accepted beats.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b1, ir);
    do_reset();
    chk("mrst_valid", bus.out_valid, 1'b0);
    cyc(1'b1, $urandom, 1'b1, ir);
    cyc(1'b0, '0, 1'b1, ir);
    chk("mrst_valid2", bus.out_valid, 1'b1);
    chk("mrst_sof", bus.out_sof, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0), ir);

    // Drain with a bounded budget.
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, '0, 1'b1, ir);
    chk("drain", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dog_diff_pipe.md
Name: dog_diff_pipe

Overview:
Parametrised Difference-of-Gaussian (DoG) stage for the SIFT pipeline.
- Accepts SCALES co-registered blurred-pixel streams, one pixel per scale per beat.
- Emits SCALES-1 signed differences per pixel, plus frame-position tags.
- Two-stage valid/ready pipeline between the Gaussian blur bank and keypoint extremum detection.
- Generalises the single signed 9-bit subtractor to N scales, parametric widths, backpressure and raster tracking.

Parameters:
PIX_W, 8, unsigned blurred-pixel width
SCALES, 4, number of input scales (≥2); produces SCALES-1 DoG layers
COLS, 640, pixels per row
ROWS, 480, rows per frame
THRESH, 3, magnitude threshold for candidate mask (used only with DOG_THRESH_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
in_pix  in  SCALES*PIX_W  scale k at bits [k*PIX_W +: PIX_W]; scale 0 = least blurred
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_dog  out  (SCALES-1)*(PIX_W+1)  layer k signed = pix[k+1]-pix[k], at [k*(PIX_W+1) +: PIX_W+1]
out_mask  out  SCALES-1  bit k = candidate flag for layer k
out_sof  out  1  beat is pixel (0,0)
out_eol  out  1  beat is last column of a row
out_eof  out  1  beat is pixel (COLS-1,ROWS-1)

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: out_valid=0; out_dog=0; out_mask=0; out_sof/eol/eof=0; internal stage valids=0; col=0; row=0.
- Reset asserted mid-frame discards all in-flight beats. The next accepted beat is tagged (0,0).
- Handshake: beat accepted when in_valid && in_ready. Beat delivered when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
- When adv=0, all pipeline registers hold.
- Stage 1 (on adv):
  - s1_valid <= accepted.
  - For each k: d[k] <= {1'b0,pix[k+1]} - {1'b0,pix[k]}, PIX_W+1 bits two's complement. Cannot overflow: range −(2^PIX_W−1)..+(2^PIX_W−1).
  - Position tags are computed from the col/row counters before they increment.
- Stage 2 (on adv):
  - out_valid <= s1_valid; out_dog <= d; tags forwarded.
  - out_mask per the optional feature.
- Latency: 2 cycles from acceptance to out_valid, with out_ready held high. Throughput is 1 beat/cycle.
- Bubbles: a beat with in_valid=0 on an adv cycle is a bubble. Bubbles propagate; they are not collapsed.
- Position counters advance only on accepted beats:
  - col increments; at col==COLS-1, col wraps to 0 and row increments.
  - At row==ROWS-1 && col==COLS-1, both wrap to 0 (frame end).
- Simultaneous stall and input: when out_valid=1 and out_ready=0, in_ready=0. Input is not consumed and counters hold.
- Output stability: while out_valid=1 and out_ready=0, out_dog, out_mask and the tags stay stable.

Optional Feature:
DOG_THRESH_EN
- Defined: stage 2 computes |d[k]| with PIX_W-bit unsigned magnitude; |−(2^PIX_W−1)| fits. out_mask[k] = (|d[k]| >= THRESH). Registered with out_dog, so latency is unchanged.
- Undefined: out_mask is tied to all-zero. No magnitude or compare logic is synthesised. THRESH is ignored.

Decomposition:
- Package sift_pkg:
  - PIX_W default
  - localparam function dog_w(PIX_W)=PIX_W+1
  - COLS/ROWS defaults
  - typedef for the position tag struct {sof, eol, eof}
- Sub-module dog_pos_cnt: col/row raster counter with wrap and tag generation. Enable = accepted beat; synchronous active-low reset.
- All else lives in dog_diff_pipe.

Test Plan (bench config: PIX_W=8, SCALES=4, COLS=4, ROWS=2, THRESH=3, DOG_THRESH_EN defined unless noted):
1. Basic diff: in_pix scales {10,20,15,15} (s0..s3), out_ready=1 → 2 cycles later out_dog = {+10,−5,0}; out_mask = 3'b011; out_sof=1.
2. Extremes: scales {255,0,255,0} → out_dog = {−255,+255,−255} (9'h101,9'h0FF,9'h101); mask = 3'b111. Macro undefined → mask = 0.
3. Raster tags: stream 8 consecutive beats → out_eol on beats 4 and 8, out_eof on beat 8 only. Beat 9 carries out_sof=1 (wrap).
4. Backpressure: out_ready=0 for 3 cycles after the first output → in_ready=0 on those cycles; out_dog held constant; no beat lost or duplicated; counters resume correctly.
5. Bubbles: in_valid pattern 1,0,1 with out_ready=1 → out_valid pattern 1,0,1 after 2 cycles; tags count only valid beats.
6. Reset mid-frame: after 5 accepted beats, rst_n=0 for 1 cycle → out_valid=0 next cycle; the next accepted beat emerges with out_sof=1.
